// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the accumulator CPU control sequencer.
// Optional interrupt support is enabled with CTRL_IRQ_EN.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        SKIP,
        HALTED,
        IRQ
    } state_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef struct packed {
        logic pc_en;
        logic pc_load;
        logic halt;
        logic acc_load;
        logic acc_sel;
        logic imem_en;
        logic dmem_en;
        logic dmem_we;
        logic jmp;
    } strobe_t;

    function automatic logic is_data_op(input logic [2:0] op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO};
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Sequencer-to-datapath bundle: memory handshakes, flags and strobes.
// irq/irq_ack exist only when CTRL_IRQ_EN is defined.
interface ctrl_sequencer_if #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                is_zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                resume;
    logic                pc_en;
    logic                pc_load;
    logic                halt;
    logic                acc_load;
    logic                acc_sel;
    logic                imem_en;
    logic                dmem_en;
    logic                dmem_we;
    logic                jmp;
    logic                err;
    logic [CNT_W-1:0]    instr_cnt;
`ifdef CTRL_IRQ_EN
    logic                irq;
    logic                irq_ack;

    modport master (
        input  opcode, is_zero, imem_ready, dmem_ready, resume, irq,
        output pc_en, pc_load, halt, acc_load, acc_sel,
        output imem_en, dmem_en, dmem_we, jmp, err, instr_cnt, irq_ack
    );

    modport slave (
        output opcode, is_zero, imem_ready, dmem_ready, resume, irq,
        input  pc_en, pc_load, halt, acc_load, acc_sel,
        input  imem_en, dmem_en, dmem_we, jmp, err, instr_cnt, irq_ack
    );
`else
    modport master (
        input  opcode, is_zero, imem_ready, dmem_ready, resume,
        output pc_en, pc_load, halt, acc_load, acc_sel,
        output imem_en, dmem_en, dmem_we, jmp, err, instr_cnt
    );

    modport slave (
        output opcode, is_zero, imem_ready, dmem_ready, resume,
        input  pc_en, pc_load, halt, acc_load, acc_sel,
        input  imem_en, dmem_en, dmem_we, jmp, err, instr_cnt
    );
`endif
endinterface

// File: rtl/ctrl_sequencer_decode.sv
// ctrl_decode: combinational strobe decode from state and latched opcode.
// The IRQ state decodes to vector load + ack only when CTRL_IRQ_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  state_e              state,
    input  logic [OPCODE_W-1:0] ir,
    input  logic                dmem_ready,
    input  logic                is_zero,
    output strobe_t             strb,
    output logic                data_op,
    output logic                hlt_op,
    output logic                skip_take
`ifdef CTRL_IRQ_EN
    , output logic              irq_ack
`endif
);

    logic       nop;
    logic [2:0] op;
    logic       sto_op;
    logic       lda_op;
    logic       jmp_op;
    logic       skz_op;

    // Opcodes wider than the defined set decode as NOP.
    if (OPCODE_W > 3) begin : g_wide
        assign nop = |ir[OPCODE_W-1:3];
    end else begin : g_narrow
        assign nop = 1'b0;
    end

    assign op      = ir[2:0];
    assign data_op = !nop && is_data_op(op);
    assign hlt_op  = !nop && (op == OP_HLT);
    assign sto_op  = !nop && (op == OP_STO);
    assign lda_op  = !nop && (op == OP_LDA);
    assign jmp_op  = !nop && (op == OP_JMP);
    assign skz_op  = !nop && (op == OP_SKZ);

    assign skip_take = (state == WRITEBACK) && skz_op && is_zero;

    always_comb begin
        strb = '0;
`ifdef CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
        unique case (state)
            FETCH: begin
                strb.imem_en = 1'b1;
            end
            DECODE: begin
                strb.imem_en = 1'b1;
                strb.dmem_en = data_op;
            end
            EXECUTE: begin
                if (data_op) begin
                    strb.dmem_en  = 1'b1;
                    strb.dmem_we  = sto_op;
                    strb.acc_load = dmem_ready && !sto_op;
                    strb.acc_sel  = dmem_ready && lda_op;
                end
                strb.jmp = jmp_op;
            end
            WRITEBACK: begin
                strb.pc_load = jmp_op;
                strb.jmp     = jmp_op;
                strb.pc_en   = !jmp_op;
            end
            SKIP: begin
                strb.pc_en = 1'b1;
            end
            HALTED: begin
                strb.halt = 1'b1;
            end
            IRQ: begin
`ifdef CTRL_IRQ_EN
                strb.pc_load = 1'b1;
                irq_ack      = 1'b1;
`endif
            end
            default: begin
                strb = '0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the accumulator CPU.
// Define CTRL_IRQ_EN to add the irq/irq_ack interrupt entry path.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input logic              clk,
    input logic              rst,
    ctrl_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_e              state;
    state_e              state_n;
    logic [OPCODE_W-1:0] ir;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                err;
    logic [CNT_W-1:0]    instr_cnt;

    strobe_t strb;
    logic    data_op;
    logic    hlt_op;
    logic    skip_take;
    logic    irq_req;
    logic    stalled;
    logic    at_limit;
    logic    timeout;
    logic    retire;

`ifdef CTRL_IRQ_EN
    logic irq_ack;
    assign irq_req     = bus.irq;
    assign bus.irq_ack = irq_ack;
`else
    assign irq_req = 1'b0;
`endif

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .state      (state),
        .ir         (ir),
        .dmem_ready (bus.dmem_ready),
        .is_zero    (bus.is_zero),
        .strb       (strb),
        .data_op    (data_op),
        .hlt_op     (hlt_op),
        .skip_take  (skip_take)
`ifdef CTRL_IRQ_EN
        , .irq_ack  (irq_ack)
`endif
    );

    // A stall is any cycle spent waiting on a memory ready.
    assign stalled  = ((state == FETCH) && !bus.imem_ready) ||
                      ((state == EXECUTE) && data_op && !bus.dmem_ready);
    assign at_limit = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        unique case (state)
            FETCH: begin
                if (bus.imem_ready) begin
                    state_n = DECODE;
                end else if (at_limit) begin
                    timeout = 1'b1;
                    state_n = HALTED;
                end
            end
            DECODE: begin
                state_n = EXECUTE;
            end
            EXECUTE: begin
                if (hlt_op) begin
                    state_n = HALTED;
                end else if (!data_op || bus.dmem_ready) begin
                    state_n = WRITEBACK;
                end else if (at_limit) begin
                    timeout = 1'b1;
                    state_n = HALTED;
                end
            end
            WRITEBACK: begin
                if (skip_take) begin
                    state_n = SKIP;
                end else begin
                    state_n = irq_req ? IRQ : FETCH;
                end
            end
            SKIP: begin
                state_n = irq_req ? IRQ : FETCH;
            end
            HALTED: begin
                if (bus.resume && !err) begin
                    state_n = WRITEBACK;
                end
            end
            IRQ: begin
                state_n = FETCH;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // An instruction retires when the sequencer leaves its last step.
    assign retire = ((state == WRITEBACK) && (state_n != SKIP)) ||
                    (state == SKIP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if ((state == FETCH) && bus.imem_ready) begin
                ir <= bus.opcode;
            end
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (stalled) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
            if (retire) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en     = strb.pc_en;
    assign bus.pc_load   = strb.pc_load;
    assign bus.halt      = strb.halt;
    assign bus.acc_load  = strb.acc_load;
    assign bus.acc_sel   = strb.acc_sel;
    assign bus.imem_en   = strb.imem_en;
    assign bus.dmem_en   = strb.dmem_en;
    assign bus.dmem_we   = strb.dmem_we;
    assign bus.jmp       = strb.jmp;
    assign bus.err       = err;
    assign bus.instr_cnt = instr_cnt;

endmodule
